// File: rtl/maze_viewport_renderer_pkg.sv
// Shared constants and helpers for the maze viewport renderer.
//   - 3-3-2 colour constants
//   - 4x4 character sprite mask, indexed by sub_x + 4*sub_y
//   - legal tile_log2 range and the clamp that enforces it
//   - path RAM address width helper
package maze_pkg;

  localparam logic [7:0]  COLOR_BLACK   = 8'h00;
  localparam logic [7:0]  COLOR_WHITE   = 8'hFF;
  localparam logic [15:0] SPRITE_MASK   = 16'b0110_1111_1111_0110;
  localparam logic [2:0]  TILE_LOG2_MIN = 3'd2;
  localparam logic [2:0]  TILE_LOG2_MAX = 3'd6;

  // 12 bits hold the largest maze extent in pixels (32 tiles << 6 = 2048).
  localparam int EXT_W = 12;

  // Path RAM address width: one row index plus one column index.
  function automatic int addr_w(input int dim_max);
    return 2 * $clog2(dim_max);
  endfunction

  // Force the tile edge exponent into the supported range.
  function automatic logic [2:0] clamp_tile_log2(input logic [2:0] t);
    logic [2:0] res;
    if (t < TILE_LOG2_MIN) begin
      res = TILE_LOG2_MIN;
    end else if (t > TILE_LOG2_MAX) begin
      res = TILE_LOG2_MAX;
    end else begin
      res = t;
    end
    return res;
  endfunction

endpackage

// File: rtl/maze_viewport_renderer_if.sv
// Path RAM bus between the renderer (master) and the 1-bit maze RAM (slave).
//   path_rd    : read strobe
//   path_addr  : ty*MAZE_DIM_MAX + tx
//   path_rdata : 1 = path, valid exactly one cycle after path_rd
interface maze_viewport_renderer_if #(
  parameter int AW = maze_pkg::addr_w(32)
) ();

  logic          path_rd;
  logic [AW-1:0] path_addr;
  logic          path_rdata;

  modport master (output path_rd, output path_addr, input path_rdata);
  modport slave  (input path_rd, input path_addr, output path_rdata);

endinterface

// File: rtl/maze_viewport_renderer_camera.sv
// Frame-latched view geometry for the maze renderer.
// On i_update (one cycle after the shadow latch) it decides between the
// centred and the scrolling view and registers:
//   o_scroll        : 1 = maze does not fit the screen, camera mode
//   o_cam_x/o_cam_y : camera origin in tiles (0 in centred mode)
//   o_bx/o_by       : top-left pixel of the centred maze (0 in scroll mode)
// Inputs are the already-shadowed size, tile exponent and character tile.
module maze_camera
  import maze_pkg::*;
#(
  parameter int  MAZE_DIM_MAX = 32,
  parameter int  H_RES        = 640,
  parameter int  V_RES        = 480,
  localparam int DW           = $clog2(MAZE_DIM_MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_update,
  input  logic [DW:0]      i_w,
  input  logic [DW:0]      i_h,
  input  logic [2:0]       i_t,
  input  logic [DW-1:0]    i_char_x,
  input  logic [DW-1:0]    i_char_y,
  output logic [DW-1:0]    o_cam_x,
  output logic [DW-1:0]    o_cam_y,
  output logic             o_scroll,
  output logic [EXT_W-1:0] o_bx,
  output logic [EXT_W-1:0] o_by
);

  // clamp(c - view/2, 0, max(dim - view, 0)) in signed arithmetic. The
  // intermediate is wider than DW+2 because the view spans computed for
  // small tiles exceed that range; those results are discarded in
  // centred mode, and in scroll mode every value fits DW+2 bits anyway.
  function automatic logic [DW-1:0] cam_clamp(input logic [DW-1:0]    c,
                                               input logic [DW:0]      dim,
                                               input logic [EXT_W-1:0] view);
    logic signed [EXT_W:0] pos;
    logic signed [EXT_W:0] lim;
    logic [DW-1:0]         res;
    pos = $signed((EXT_W+1)'(c)) - $signed((EXT_W+1)'(view >> 1));
    lim = $signed((EXT_W+1)'(dim)) - $signed((EXT_W+1)'(view));
    if (lim < $signed(13'sd0)) begin
      lim = 13'sd0;
    end else begin
      lim = lim;
    end
    if (pos < $signed(13'sd0)) begin
      res = {DW{1'b0}};
    end else if (pos > lim) begin
      res = lim[DW-1:0];
    end else begin
      res = pos[DW-1:0];
    end
    return res;
  endfunction

  logic [EXT_W-1:0] w_ext_w;
  logic [EXT_W-1:0] w_ext_h;
  logic             w_fit;
  logic [EXT_W-1:0] w_vx;
  logic [EXT_W-1:0] w_vy;

  // Maze extent in pixels, fit test and visible tile span
  always_comb begin
    w_ext_w = EXT_W'(i_w) << i_t;
    w_ext_h = EXT_W'(i_h) << i_t;
    w_fit   = (w_ext_w <= EXT_W'(H_RES)) && (w_ext_h <= EXT_W'(V_RES));
    w_vx    = EXT_W'(H_RES) >> i_t;
    w_vy    = EXT_W'(V_RES) >> i_t;
  end

  // Geometry registers, refreshed once per frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_scroll <= 1'b0;
      o_cam_x  <= {DW{1'b0}};
      o_cam_y  <= {DW{1'b0}};
      o_bx     <= {EXT_W{1'b0}};
      o_by     <= {EXT_W{1'b0}};
    end else if (i_update) begin
      o_scroll <= !w_fit;
      o_cam_x  <= w_fit ? {DW{1'b0}} : cam_clamp(i_char_x, i_w, w_vx);
      o_cam_y  <= w_fit ? {DW{1'b0}} : cam_clamp(i_char_y, i_h, w_vy);
      o_bx     <= w_fit ? ((EXT_W'(H_RES) - w_ext_w) >> 1) : {EXT_W{1'b0}};
      o_by     <= w_fit ? ((EXT_W'(V_RES) - w_ext_h) >> 1) : {EXT_W{1'b0}};
    end
  end

endmodule

// File: rtl/maze_viewport_renderer.sv
// Pipelined maze pixel generator between vga_sync and the rgb pins.
// Ports:
//   clk, reset (async, active-low)
//   enable, frame_start, pixel_x/pixel_y, video_on   : timing from vga_sync
//   maze_width/maze_height, tile_log2, char_x/char_y : per-frame config
//   path_color, char_color, wall_color               : 3-3-2 colours
//   path_bus (master)                                : 1-bit maze RAM port
//   rgb, video_on_out                                : pixel out, 3 cycles
//   cam_x, cam_y, scroll_mode                        : current view state
// Stages: S1 tile lookup + RAM strobe, S2 RAM access, S3 colour mux.
module maze_viewport_renderer
  import maze_pkg::*;
#(
  parameter int  MAZE_DIM_MAX = 32,
  parameter int  H_RES        = 640,
  parameter int  V_RES        = 480,
  parameter int  COLOR_W      = 8,
  localparam int DW           = $clog2(MAZE_DIM_MAX)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     frame_start,
  input  logic [9:0]               pixel_x,
  input  logic [9:0]               pixel_y,
  input  logic                     video_on,
  input  logic [DW:0]              maze_width,
  input  logic [DW:0]              maze_height,
  input  logic [2:0]               tile_log2,
  input  logic [DW-1:0]            char_x,
  input  logic [DW-1:0]            char_y,
  input  logic [COLOR_W-1:0]       path_color,
  input  logic [COLOR_W-1:0]       char_color,
  input  logic [COLOR_W-1:0]       wall_color,
  maze_viewport_renderer_if.master path_bus,
  output logic [COLOR_W-1:0]       rgb,
  output logic                     video_on_out,
  output logic [DW-1:0]            cam_x,
  output logic [DW-1:0]            cam_y,
  output logic                     scroll_mode
);

  localparam logic [DW:0] DIM_MAX = (DW+1)'(MAZE_DIM_MAX);

  // Shadowed configuration
  logic [DW:0]        r_w;
  logic [DW:0]        r_h;
  logic [2:0]         r_t;
  logic [DW-1:0]      r_cx;
  logic [DW-1:0]      r_cy;
  logic [COLOR_W-1:0] r_path_col;
  logic [COLOR_W-1:0] r_char_col;
  logic [COLOR_W-1:0] r_wall_col;
  logic               r_fs_d;

  // Per-frame latch of configuration; sizes saturate, exponent clamps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w        <= {(DW+1){1'b0}};
      r_h        <= {(DW+1){1'b0}};
      r_t        <= TILE_LOG2_MIN;
      r_cx       <= {DW{1'b0}};
      r_cy       <= {DW{1'b0}};
      r_path_col <= {COLOR_W{1'b0}};
      r_char_col <= {COLOR_W{1'b0}};
      r_wall_col <= {COLOR_W{1'b0}};
    end else if (frame_start) begin
      r_w        <= (maze_width  > DIM_MAX) ? DIM_MAX : maze_width;
      r_h        <= (maze_height > DIM_MAX) ? DIM_MAX : maze_height;
      r_t        <= clamp_tile_log2(tile_log2);
      r_cx       <= char_x;
      r_cy       <= char_y;
      r_path_col <= path_color;
      r_char_col <= char_color;
      r_wall_col <= wall_color;
    end
  end

  // Camera/border refresh trails the shadow latch by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fs_d <= 1'b0;
    end else begin
      r_fs_d <= frame_start;
    end
  end

  logic [EXT_W-1:0] w_bx;
  logic [EXT_W-1:0] w_by;

  maze_camera #(
    .MAZE_DIM_MAX (MAZE_DIM_MAX),
    .H_RES        (H_RES),
    .V_RES        (V_RES)
  ) u_camera (
    .clk      (clk),
    .reset    (reset),
    .i_update (r_fs_d),
    .i_w      (r_w),
    .i_h      (r_h),
    .i_t      (r_t),
    .i_char_x (r_cx),
    .i_char_y (r_cy),
    .o_cam_x  (cam_x),
    .o_cam_y  (cam_y),
    .o_scroll (scroll_mode),
    .o_bx     (w_bx),
    .o_by     (w_by)
  );

  // S1 combinational lookup
  logic [EXT_W-1:0] w_px;
  logic [EXT_W-1:0] w_py;
  logic [EXT_W-1:0] w_ext_w;
  logic [EXT_W-1:0] w_ext_h;
  logic [EXT_W-1:0] w_offx;
  logic [EXT_W-1:0] w_offy;
  logic [EXT_W-1:0] w_tx;
  logic [EXT_W-1:0] w_ty;
  logic             w_zero;
  logic             w_in_c;
  logic             w_outside_c;
  logic             w_out_s;
  logic [1:0]       w_subx;
  logic [1:0]       w_suby;
  logic             w_spr;
  logic             w_black;
  logic             w_read;
  logic [2*DW-1:0]  w_addr;

  // Tile and sub-tile position of the incoming pixel
  always_comb begin
    w_px    = EXT_W'(pixel_x);
    w_py    = EXT_W'(pixel_y);
    w_ext_w = EXT_W'(r_w) << r_t;
    w_ext_h = EXT_W'(r_h) << r_t;
    w_zero  = (r_w == {(DW+1){1'b0}}) || (r_h == {(DW+1){1'b0}});
    w_in_c  = (w_px >= w_bx) && (w_px < (w_bx + w_ext_w)) &&
              (w_py >= w_by) && (w_py < (w_by + w_ext_h));
    if (scroll_mode) begin
      // Camera origin is tile-aligned, so the screen offset is the tile offset.
      w_offx = w_px;
      w_offy = w_py;
      w_tx   = EXT_W'(cam_x) + (w_px >> r_t);
      w_ty   = EXT_W'(cam_y) + (w_py >> r_t);
    end else begin
      w_offx = w_px - w_bx;
      w_offy = w_py - w_by;
      w_tx   = w_offx >> r_t;
      w_ty   = w_offy >> r_t;
    end
    w_outside_c = !scroll_mode && !w_in_c;
    w_out_s     = scroll_mode && ((w_tx >= EXT_W'(r_w)) || (w_ty >= EXT_W'(r_h)));
    // Sub-tile cell in a 4x4 grid: top two bits of the in-tile offset.
    w_subx  = 2'(w_offx >> (r_t - 3'd2));
    w_suby  = 2'(w_offy >> (r_t - 3'd2));
    w_spr   = !w_outside_c && !w_out_s &&
              (w_tx == EXT_W'(r_cx)) && (w_ty == EXT_W'(r_cy)) &&
              SPRITE_MASK[{w_suby, w_subx}];
    w_black = !video_on || !enable || w_zero || w_outside_c;
    w_read  = video_on && !w_zero && !w_outside_c && !w_out_s;
    w_addr  = {w_ty[DW-1:0], w_tx[DW-1:0]};
  end

  logic            r1_rd;
  logic [2*DW-1:0] r1_addr;
  logic            r1_von;
  logic            r1_black;
  logic            r1_wall;
  logic            r1_spr;
  logic            r2_von;
  logic            r2_black;
  logic            r2_wall;
  logic            r2_spr;

  // S1/S2 registers: RAM strobe plus flags travelling with the pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_rd    <= 1'b0;
      r1_addr  <= {(2*DW){1'b0}};
      r1_von   <= 1'b0;
      r1_black <= 1'b1;
      r1_wall  <= 1'b0;
      r1_spr   <= 1'b0;
      r2_von   <= 1'b0;
      r2_black <= 1'b1;
      r2_wall  <= 1'b0;
      r2_spr   <= 1'b0;
    end else begin
      r1_rd    <= w_read;
      if (w_read) begin
        r1_addr <= w_addr;
      end
      r1_von   <= video_on;
      r1_black <= w_black;
      r1_wall  <= w_out_s;
      r1_spr   <= w_spr;
      r2_von   <= r1_von;
      r2_black <= r1_black;
      r2_wall  <= r1_wall;
      r2_spr   <= r1_spr;
    end
  end

  assign path_bus.path_rd   = r1_rd;
  assign path_bus.path_addr = r1_addr;

  logic [COLOR_W-1:0] w_rgb_nxt;

  // S3 colour priority: blank, off-maze wall, sprite, path, wall
  always_comb begin
    w_rgb_nxt = COLOR_W'(COLOR_BLACK);
    if (r2_black) begin
      w_rgb_nxt = COLOR_W'(COLOR_BLACK);
    end else if (r2_wall) begin
      w_rgb_nxt = r_wall_col;
    end else if (r2_spr) begin
      w_rgb_nxt = r_char_col;
    end else if (path_bus.path_rdata) begin
      w_rgb_nxt = r_path_col;
    end else begin
      w_rgb_nxt = r_wall_col;
    end
  end

  // S3 output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb          <= {COLOR_W{1'b0}};
      video_on_out <= 1'b0;
    end else begin
      rgb          <= w_rgb_nxt;
      video_on_out <= r2_von;
    end
  end

endmodule
